// File: rtl/cart_pkg.sv
// Shared types and constants for cartridge bankswitch detection:
// scheme codes, image sizes and opcode-signature bytes.
package cart_pkg;

  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RESOLVE,
    ST_DONE
  } det_state_t;

  localparam int unsigned K4  = 4096;
  localparam int unsigned K8  = 8192;
  localparam int unsigned K10 = 10240;
  localparam int unsigned K12 = 12288;
  localparam int unsigned K16 = 16384;
  localparam int unsigned K32 = 32768;

  // E0: LDA/STA abs into the $1FE0-$1FE7 hotspots (either mirror)
  localparam logic [7:0]  SIG_E0_OP_A = 8'h8D;
  localparam logic [7:0]  SIG_E0_OP_B = 8'hAD;
  localparam logic [4:0]  SIG_E0_LO   = 5'b11100;
  localparam logic [7:0]  SIG_E0_HI_A = 8'h1F;
  localparam logic [7:0]  SIG_E0_HI_B = 8'hFF;
  // 3F: STA zp $3F
  localparam logic [15:0] SIG_3F      = 16'h853F;
  // FE: JSR $D000/$F000 followed by DEC
  localparam logic [31:0] SIG_FE_A    = 32'h2000D0C6;
  localparam logic [31:0] SIG_FE_B    = 32'h2000F0C6;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/bs_sig_scan.sv
// Sliding 4-byte window over the ioctl byte stream with saturating
// hit counters for the E0, 3F and FE opcode signatures.
module bs_sig_scan
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_data,
  output logic [1:0]        o_hit_e0,
  output logic [1:0]        o_hit_3f,
  output logic [1:0]        o_hit_fe
);

  logic [31:0]       r_win;
  logic [ADDR_W-1:0] r_last_addr;
  logic [1:0]        r_hit_e0;
  logic [1:0]        r_hit_3f;
  logic [1:0]        r_hit_fe;

  logic              w_seq;
  logic [31:0]       w_win_next;
  logic              w_e0;
  logic              w_3f;
  logic              w_fe;

  // A non-contiguous write breaks any signature spanning the gap
  assign w_seq      = (i_addr == '0) || (i_addr == r_last_addr + ADDR_W'(1));
  assign w_win_next = {(w_seq ? r_win[23:0] : 24'h0), i_data};

  assign w_e0 = ((w_win_next[23:16] == SIG_E0_OP_A) || (w_win_next[23:16] == SIG_E0_OP_B)) &&
                (w_win_next[15:11] == SIG_E0_LO) &&
                ((w_win_next[7:0] == SIG_E0_HI_A) || (w_win_next[7:0] == SIG_E0_HI_B));
  assign w_3f = (w_win_next[15:0] == SIG_3F);
  assign w_fe = (w_win_next == SIG_FE_A) || (w_win_next == SIG_FE_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_last_addr <= '0;
      r_hit_e0    <= '0;
      r_hit_3f    <= '0;
      r_hit_fe    <= '0;
    end else if (i_clr) begin
      r_win       <= '0;
      r_last_addr <= '0;
      r_hit_e0    <= '0;
      r_hit_3f    <= '0;
      r_hit_fe    <= '0;
    end else if (i_wr) begin
      r_win       <= w_win_next;
      r_last_addr <= i_addr;
      if (w_e0) r_hit_e0 <= sat_inc2(r_hit_e0);
      if (w_3f) r_hit_3f <= sat_inc2(r_hit_3f);
      if (w_fe) r_hit_fe <= sat_inc2(r_hit_fe);
    end
  end

  assign o_hit_e0 = r_hit_e0;
  assign o_hit_3f = r_hit_3f;
  assign o_hit_fe = r_hit_fe;

endmodule

// File: rtl/cart_bs_detect.sv
// Watches the HPS cartridge download and resolves the bankswitch scheme,
// SuperChip enable and ROM size from extension hints, size and signatures.
module cart_bs_detect
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned SC_BYTES = 128
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [3:0]        ext_bs,
  input  logic              ext_sc,
  input  logic [1:0]        sc_mode,
  output bs_t               force_bs,
  output logic              sc,
  output logic [ADDR_W-1:0] rom_size,
  output logic              detect_done,
  output logic              busy
);

  det_state_t        r_state;
  det_state_t        w_state_next;
  logic              r_dl_q;
  logic [3:0]        r_ext_bs;
  logic              r_ext_sc;
  logic [1:0]        r_sc_mode;
  logic [ADDR_W-1:0] r_size;
  logic [7:0]        r_byte0;
  logic              r_sc_cand;
  logic              r_sc_kill;
  bs_t               r_force_bs;
  logic              r_sc;
  logic [ADDR_W-1:0] r_rom_size;
  logic              r_done;
  logic              r_busy;

  logic              w_rise;
  logic              w_fall;
  logic              w_start;
  logic              w_capture;
  logic              w_wr;
  logic [ADDR_W:0]   w_addr_p1;
  logic [ADDR_W-1:0] w_addr_p1_sat;
  logic [1:0]        w_hit_e0;
  logic [1:0]        w_hit_3f;
  logic [1:0]        w_hit_fe;
  bs_t               w_bs;
  logic              w_sc;

  assign w_rise = ioctl_download & ~r_dl_q;
  assign w_fall = ~ioctl_download & r_dl_q;
  assign w_wr   = ioctl_wr && (r_state == ST_LOAD);

  assign w_addr_p1     = {1'b0, ioctl_addr} + (ADDR_W + 1)'(1);
  assign w_addr_p1_sat = w_addr_p1[ADDR_W] ? '1 : w_addr_p1[ADDR_W-1:0];

  bs_sig_scan #(.ADDR_W(ADDR_W)) u_scan (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .i_clr    (w_start),
    .i_wr     (w_wr),
    .i_addr   (ioctl_addr),
    .i_data   (ioctl_dout),
    .o_hit_e0 (w_hit_e0),
    .o_hit_3f (w_hit_3f),
    .o_hit_fe (w_hit_fe)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // A new download rising edge outside LOAD abandons any pending result
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_LOAD;
          w_start      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_fall) w_state_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (w_rise) begin
          w_state_next = ST_LOAD;
          w_start      = 1'b1;
        end else begin
          w_state_next = ST_DONE;
          w_capture    = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_rise) begin
          w_state_next = ST_LOAD;
          w_start      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Resolve priority: extension, tiny image, 3F signature, then by size
  always_comb begin
    w_bs = BS_NONE;
    if (r_ext_bs != 4'd0) begin
      w_bs = bs_t'(r_ext_bs);
    end else if (r_size <= ADDR_W'(K4)) begin
      w_bs = BS_NONE;
    end else if (w_hit_3f >= 2'd2) begin
      w_bs = BS_3F;
    end else if (r_size == ADDR_W'(K8)) begin
      if (w_hit_e0 >= 2'd2)      w_bs = BS_E0;
      else if (w_hit_fe != 2'd0) w_bs = BS_FE;
      else                       w_bs = BS_F8;
    end else if (r_size == ADDR_W'(K12)) begin
      w_bs = BS_FA;
    end else if (r_size == ADDR_W'(K16)) begin
      w_bs = (w_hit_e0 >= 2'd2) ? BS_E0 : BS_F6;
    end else if (r_size == ADDR_W'(K32)) begin
      w_bs = BS_F4;
    end else if ((r_size == ADDR_W'(K10)) || (r_size == ADDR_W'(K10 + 255))) begin
      w_bs = BS_P2;
    end
  end

  always_comb begin
    w_sc = 1'b0;
    case (r_sc_mode)
      2'd1:    w_sc = 1'b0;
      2'd2:    w_sc = 1'b1;
      default: w_sc = r_ext_sc | (r_sc_cand & (r_size >= ADDR_W'(K8)));
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_q     <= 1'b0;
      r_ext_bs   <= '0;
      r_ext_sc   <= 1'b0;
      r_sc_mode  <= '0;
      r_size     <= '0;
      r_byte0    <= '0;
      r_sc_cand  <= 1'b0;
      r_sc_kill  <= 1'b0;
      r_force_bs <= BS_NONE;
      r_sc       <= 1'b0;
      r_rom_size <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (w_state_next == ST_DONE);
      if (w_start) begin
        r_ext_bs  <= ext_bs;
        r_ext_sc  <= ext_sc;
        r_sc_mode <= sc_mode;
        r_size    <= '0;
        r_byte0   <= '0;
        r_sc_cand <= 1'b0;
        r_sc_kill <= 1'b0;
      end else if (w_wr) begin
        if (w_addr_p1_sat > r_size) r_size <= w_addr_p1_sat;
        // SuperChip images keep a uniform fill over the RAM window
        if (ioctl_addr == '0) begin
          r_byte0   <= ioctl_dout;
          r_sc_cand <= ~r_sc_kill;
        end else if ((ioctl_addr < ADDR_W'(SC_BYTES)) && (ioctl_dout != r_byte0)) begin
          r_sc_cand <= 1'b0;
          r_sc_kill <= 1'b1;
        end
      end
      if (w_capture) begin
        r_force_bs <= w_bs;
        r_sc       <= w_sc;
        r_rom_size <= r_size;
      end
    end
  end

  assign force_bs    = r_force_bs;
  assign sc          = r_sc;
  assign rom_size    = r_rom_size;
  assign detect_done = r_done;
  assign busy        = r_busy;

endmodule
